muldiv_seq: RTL
===============

MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high (RstEnable).
REQ-003 SHALL have port start_i, input, 1 bit: EX holds a multi-cycle op and holds it high until it sees ready_o.
REQ-004 SHALL have port op_i, input, 2 bits: 00 MADD, 01 MSUB, 10 DIV, 11 reserved (treated as no request).
REQ-005 SHALL have port signed_i, input, 1 bit: 1 selects signed MADD/MSUB/DIV; 0 selects the U variants.
REQ-006 SHALL have port opdata1_i, input, 32 bits: multiplicand or dividend.
REQ-007 SHALL have port opdata2_i, input, 32 bits: multiplier or divisor.
REQ-008 SHALL have port hilo_i, input, 64 bits: forwarded {HI,LO} accumulator, already resolved for MEM/WB hazards.
REQ-009 SHALL have port annul_i, input, 1 bit: cancel the in-flight op (flush).
REQ-010 SHALL have port result_o, output, 64 bits: {HI,LO} value to write.
REQ-011 SHALL have port ready_o, output, 1 bit: result_o is valid.
REQ-012 SHALL have port stallreq_o, output, 1 bit: pipeline stall request to ctrl.

Function
REQ-013 SHALL implement states IDLE, MAC, DIV_ON, DIV_ZERO and DONE in a registered FSM.
REQ-014 IDLE SHALL take start_i with op 00/01 to MAC, and latch the 64-bit product of opdata1_i and opdata2_i (signed per signed_i).
REQ-015 IDLE SHALL take start_i with op 10 to DIV_ZERO when opdata2_i==0, and otherwise to DIV_ON, latching the operand magnitudes and clearing the iteration counter.
REQ-016 MAC SHALL latch result = hilo_i + product (MADD) or hilo_i - product (MSUB), mod 2^64, and go to DONE; from start to ready_o is 2 cycles.
REQ-017 DIV_ON SHALL perform one restoring shift-subtract step per cycle for 32 cycles (5-bit counter 0..31), then go to DONE; from start to ready_o is 33 cycles.
REQ-018 Signed DIV SHALL divide magnitudes, negate the quotient when operand signs differ, and give the remainder the dividend's sign.
REQ-019 The DIV result SHALL be result_o[63:32] = remainder and result_o[31:0] = quotient.
REQ-020 DIV_ZERO SHALL latch result 0 and go to DONE after 1 cycle.
REQ-021 DONE SHALL drive ready_o=1 and hold result_o, and SHALL return to IDLE only when start_i==0; it SHALL NOT restart while start_i remains high.
REQ-022 stallreq_o SHALL be combinational: (start_i && op valid && state!=DONE) && !annul_i.
REQ-023 Outside DONE, ready_o SHALL be 0 and result_o SHALL be 0.
REQ-024 annul_i high in any state SHALL force IDLE at the next edge, discard partial results and hold ready_o at 0; annul_i has priority over start_i.
REQ-025 Operand inputs SHALL be ignored after IDLE captures them; changes mid-operation SHALL NOT affect the result.

Reset
REQ-026 On rst high, asynchronously: state=IDLE, counter=0, all datapath registers=0, ready_o=0, result_o=0.
REQ-027 Reset during DIV_ON or MAC SHALL abort the op; after release, IDLE SHALL accept a new start_i.

Structure
REQ-028 The op_i encodings, state encodings, and DivResultReady/DivResultNotReady constants SHALL be added to defines.v.
REQ-029 One sub-module, div_step (one 33-bit compare/subtract iteration, combinational), SHALL be instantiated; the multiplier stays inline.

Verification
REQ-030 MADD signed, hilo_i=64'h1, opdata1_i=-2, opdata2_i=3 -> ready_o at cycle 2, result_o=64'hFFFFFFFF_FFFFFFFB.
REQ-031 MSUB unsigned, hilo_i=100, opdata1_i=7, opdata2_i=5 -> result_o=65; stallreq_o high for 2 cycles.
REQ-032 DIV signed, opdata1_i=-7, opdata2_i=2 -> ready_o at cycle 33, result_o={32'hFFFFFFFF, 32'hFFFFFFFD}.
REQ-033 DIVU, opdata1_i=32'hFFFFFFFF, opdata2_i=0 -> DIV_ZERO, then ready_o at cycle 2, result_o=0.
REQ-034 DIV with annul_i pulsed at iteration 10 -> IDLE next cycle, ready_o never asserted; an immediate restart divides correctly.
REQ-035 Async rst asserted mid-DIV_ON between clock edges -> outputs 0 immediately; start_i held through DONE -> no second op begins.

Source files
------------

// File: rtl/muldiv_seq_pkg.sv
// Shared encodings and helpers for the sequential multiply-accumulate / divide unit.
package muldiv_seq_pkg;

  typedef enum logic [1:0] {
    OP_MADD = 2'b00,
    OP_MSUB = 2'b01,
    OP_DIV  = 2'b10,
    OP_RSVD = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_MAC      = 3'd1,
    S_DIV_ON   = 3'd2,
    S_DIV_ZERO = 3'd3,
    S_DONE     = 3'd4
  } state_e;

  localparam logic       DIV_RESULT_READY     = 1'b1;
  localparam logic       DIV_RESULT_NOT_READY = 1'b0;
  localparam logic [4:0] DIV_LAST_ITER        = 5'd31;

  // Magnitude of a 32-bit operand; only negative values are flipped in signed mode.
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (32'd0 - v) : v;
  endfunction

endpackage

// File: rtl/muldiv_seq_div_step.sv
// One restoring shift-subtract iteration: shifts the next dividend bit into the
// partial remainder and subtracts the divisor when it fits.
module div_step (
  input  logic [31:0] rem_i,
  input  logic [31:0] quo_i,
  input  logic [31:0] divisor_i,
  output logic [31:0] rem_o,
  output logic [31:0] quo_o
);

  logic [32:0] partial;
  logic [32:0] diff;

  assign partial = {rem_i, quo_i[31]};
  assign diff    = partial - {1'b0, divisor_i};

  // Remainder stays below the divisor, so a borrow shows up in bit 32.
  assign rem_o = diff[32] ? partial[31:0] : diff[31:0];
  assign quo_o = {quo_i[30:0], ~diff[32]};

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle MADD/MSUB (2 cycles) and 32-iteration restoring DIV (33 cycles)
// unit holding its {HI,LO} result until the requester drops start_i.
module muldiv_seq
  import muldiv_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [1:0]  op_i,
  input  logic        signed_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic [63:0] hilo_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o,
  output logic        stallreq_o
);

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvsr_q, dvsr_d;
  logic        is_msub_q, is_msub_d;
  logic        neg_quo_q, neg_quo_d;
  logic        neg_rem_q, neg_rem_d;

  op_e         op;
  logic [63:0] ext_a, ext_b, product;
  logic [31:0] step_rem, step_quo;

  assign op = op_e'(op_i);

  // Sign- or zero-extend to 64 bits so one truncated multiplier serves both variants.
  assign ext_a   = {{32{signed_i & opdata1_i[31]}}, opdata1_i};
  assign ext_b   = {{32{signed_i & opdata2_i[31]}}, opdata2_i};
  assign product = ext_a * ext_b;

  div_step u_div_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (dvsr_q),
    .rem_o     (step_rem),
    .quo_o     (step_quo)
  );

  // NOTE: datapath registers are reset along with the FSM so a fresh op never sees stale values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      is_msub_q <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvsr_q    <= dvsr_d;
      is_msub_q <= is_msub_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
    end
  end

  always_comb begin
    // NOTE: every target gets a hold default first, so no path can infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvsr_d    = dvsr_q;
    is_msub_d = is_msub_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;

    if (annul_i) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      acc_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start_i && (op == OP_MADD || op == OP_MSUB)) begin
            state_d   = S_MAC;
            acc_d     = product;
            is_msub_d = (op == OP_MSUB);
          end else if (start_i && op == OP_DIV) begin
            state_d   = (opdata2_i == 32'd0) ? S_DIV_ZERO : S_DIV_ON;
            cnt_d     = '0;
            rem_d     = '0;
            quo_d     = mag32(opdata1_i, signed_i);
            dvsr_d    = mag32(opdata2_i, signed_i);
            neg_quo_d = signed_i & (opdata1_i[31] ^ opdata2_i[31]);
            neg_rem_d = signed_i & opdata1_i[31];
          end
        end
        S_MAC: begin
          acc_d   = is_msub_q ? (hilo_i - acc_q) : (hilo_i + acc_q);
          state_d = S_DONE;
        end
        S_DIV_ON: begin
          rem_d = step_rem;
          quo_d = step_quo;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == DIV_LAST_ITER) begin
            // Last iteration: apply signs while packing {remainder, quotient}.
            acc_d   = {neg_rem_q ? (32'd0 - step_rem) : step_rem,
                       neg_quo_q ? (32'd0 - step_quo) : step_quo};
            state_d = S_DONE;
          end
        end
        S_DIV_ZERO: begin
          acc_d   = '0;
          state_d = S_DONE;
        end
        S_DONE: begin
          if (!start_i) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    ready_o    = DIV_RESULT_NOT_READY;
    result_o   = '0;
    stallreq_o = start_i && (op != OP_RSVD) && (state_q != S_DONE) && !annul_i;
    if (state_q == S_DONE && !annul_i) begin
      ready_o  = DIV_RESULT_READY;
      result_o = acc_q;
    end
  end

endmodule
